chord_scheduler: RTL

//  Sequences a stream of song items onto a pool of NUM_VOICES note_player instances.

---
 rtl/chord_sched_pkg.sv | 11 +
 rtl/chord_scheduler_if.sv | 33 +++
 rtl/chord_scheduler_voice_alloc.sv | 63 ++++++
 rtl/chord_scheduler.sv | 104 ++++++++++
 4 files changed

// File: rtl/chord_sched_pkg.sv
// Shared FSM state encoding and default widths for chord_scheduler.
// Optional build macro VOICE_STEAL_EN only affects voice_alloc and the top-level ready term.
package chord_sched_pkg;
  localparam int NUM_VOICES_DEF = 3;
  localparam int NOTE_W_DEF     = 6;
  localparam int DUR_W_DEF      = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
endpackage

// File: rtl/chord_scheduler_if.sv
// Song-item handshake, play/beat controls and per-voice note_player bus for chord_scheduler.
// slave = scheduler side, master = song_reader / note_player pool / control side.
interface chord_scheduler_if
  import chord_sched_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int DUR_W      = DUR_W_DEF
);
  logic                         play;
  logic                         beat;
  logic                         item_valid;
  logic                         item_advance;
  logic [NOTE_W-1:0]            item_note;
  logic [DUR_W-1:0]             item_dur;
  logic                         item_ready;
  logic [NUM_VOICES-1:0]        voice_done;
  logic [NUM_VOICES-1:0]        voice_load;
  logic [NUM_VOICES*NOTE_W-1:0] voice_note;
  logic [NUM_VOICES*DUR_W-1:0]  voice_dur;
  logic [NUM_VOICES-1:0]        voice_enable;
  logic                         song_idle;

  modport slave (
    input  play, beat, item_valid, item_advance, item_note, item_dur, voice_done,
    output item_ready, voice_load, voice_note, voice_dur, voice_enable, song_idle
  );

  modport master (
    output play, beat, item_valid, item_advance, item_note, item_dur, voice_done,
    input  item_ready, voice_load, voice_note, voice_dur, voice_enable, song_idle
  );
endinterface

// File: rtl/chord_scheduler_voice_alloc.sv
// voice_alloc: per-voice pending bits, free vector and lowest-index pick.
// With VOICE_STEAL_EN a round-robin steal_ptr supplies the index when no voice is free.
module voice_alloc #(
  parameter int NUM_VOICES = 3,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_VOICES-1:0] i_voice_done,
  input  logic [NUM_VOICES-1:0] i_load,
`ifdef VOICE_STEAL_EN
  input  logic                  i_note_acc,
`endif
  output logic                  o_any_free,
  output logic                  o_all_free,
  output logic [IDX_W-1:0]      o_alloc_idx
);
  logic [NUM_VOICES-1:0] r_pending;
  logic [NUM_VOICES-1:0] w_free;
  logic [IDX_W-1:0]      w_low_idx;

  // pending bridges the cycles before note_player drops done after a load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (i_load[i])
          r_pending[i] <= 1'b1;
        else if (!i_voice_done[i])
          r_pending[i] <= 1'b0;
      end
    end
  end

  // a load still in its output register counts as taken
  assign w_free     = i_voice_done & ~r_pending & ~i_load;
  assign o_any_free = |w_free;
  assign o_all_free = &w_free;

  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (w_free[i]) w_low_idx = IDX_W'(i);
    end
  end

`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0] r_steal_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_steal_ptr <= '0;
    end else if (i_note_acc && !o_any_free) begin
      r_steal_ptr <= (r_steal_ptr == IDX_W'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + IDX_W'(1);
    end
  end

  assign o_alloc_idx = o_any_free ? w_low_idx : r_steal_ptr;
`else
  assign o_alloc_idx = w_low_idx;
`endif
endmodule

// File: rtl/chord_scheduler.sv
// chord_scheduler: NOTE items go to a free voice (voice_load one cycle after accept), ADVANCE items wait N beats.
// Stalls item_ready when every voice is busy unless built with VOICE_STEAL_EN.
module chord_scheduler
  import chord_sched_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int DUR_W      = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  chord_scheduler_if.slave bus
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [1:0]            r_state;
  logic [DUR_W-1:0]      r_cnt;
  logic [NUM_VOICES-1:0] r_load;
  logic [NOTE_W-1:0]     r_note [NUM_VOICES];
  logic [DUR_W-1:0]      r_dur  [NUM_VOICES];

  logic                  w_any_free;
  logic                  w_all_free;
  logic [IDX_W-1:0]      w_alloc_idx;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_note_acc;

  voice_alloc #(
    .NUM_VOICES (NUM_VOICES),
    .IDX_W      (IDX_W)
  ) u_voice_alloc (
    .clk          (clk),
    .reset        (reset),
    .i_voice_done (bus.voice_done),
    .i_load       (r_load),
`ifdef VOICE_STEAL_EN
    .i_note_acc   (w_note_acc),
`endif
    .o_any_free   (w_any_free),
    .o_all_free   (w_all_free),
    .o_alloc_idx  (w_alloc_idx)
  );

`ifdef VOICE_STEAL_EN
  assign w_ready = (r_state == ST_RUN) && bus.play;
`else
  assign w_ready = (r_state == ST_RUN) && bus.play && (bus.item_advance || w_any_free);
`endif
  assign w_accept   = bus.item_valid && w_ready;
  assign w_note_acc = w_accept && !bus.item_advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_load  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= '0;
        r_dur[i]  <= '0;
      end
    end else begin
      r_load <= '0;
      case (r_state)
        ST_IDLE: begin
          if (bus.play) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_accept && bus.item_advance && (bus.item_dur != '0)) begin
            r_cnt   <= bus.item_dur;
            r_state <= ST_WAIT;
          end
          if (w_note_acc) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (w_alloc_idx == IDX_W'(i)) begin
                r_load[i] <= 1'b1;
                r_note[i] <= bus.item_note;
                r_dur[i]  <= bus.item_dur;
              end
            end
          end
        end
        ST_WAIT: begin
          // the final beat returns to RUN; the next item is taken the cycle after
          if (bus.beat && bus.play) begin
            r_cnt <= r_cnt - DUR_W'(1);
            if (r_cnt == DUR_W'(1)) r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign bus.voice_note[g*NOTE_W +: NOTE_W] = r_note[g];
    assign bus.voice_dur[g*DUR_W +: DUR_W]    = r_dur[g];
  end

  assign bus.item_ready   = w_ready;
  assign bus.voice_load   = r_load;
  assign bus.voice_enable = {NUM_VOICES{bus.play}};
  assign bus.song_idle    = (r_state == ST_RUN) && w_all_free && !bus.item_valid;
endmodule
